// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Parametrised pipeline-stage register with a valid/ready handshake. It sits
// between CPU pipeline stages (IF/ID, ID/EX, ...) and carries any payload
// width. A synchronous flush kills every held entry and loads a programmable
// bubble value onto out_data. A saturating counter records the cycles in which
// downstream back-pressure holds a valid entry.
//
// Build option:
//   PIPE_SKID_EN  defined   -> two-entry skid buffer. in_ready comes straight
//                              from a register, so there is no combinational
//                              path from out_ready to in_ready.
//                 undefined -> single entry. in_ready = !out_valid | out_ready
//                              (combinational).
//
// Parameters:
//   DATA_W     payload width in bits
//   FLUSH_VAL  value loaded into out_data on reset or flush
//   CNT_W      width of the stall counter
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept an entry
//   in_data    in   upstream payload [DATA_W]
//   out_valid  out  output entry valid
//   out_ready  in   downstream accepts
//   out_data   out  output payload [DATA_W]
//   occupancy  out  number of entries held (0..2)
//   stall_cnt  out  saturating count of back-pressure cycles [CNT_W]
//   cnt_clr    in   synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int unsigned       DATA_W    = 96,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ONE   = 1'b1
    } state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  main_d;
    logic               out_valid_q;
    logic [CNT_W-1:0]   stall_q;
    logic               in_fire;
    logic               out_fire;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0]  skid_q;
    logic [DATA_W-1:0]  skid_d;
    logic               in_ready_q;
    logic [1:0]         occ_q;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
`ifdef PIPE_SKID_EN
    // Registered ready: deasserted only while the skid entry is occupied.
    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;
`else
    // Single entry: a held entry can be replaced in the same cycle it leaves.
    assign in_ready  = !out_valid_q || out_ready;
    assign occupancy = {1'b0, out_valid_q};
`endif

    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath selection
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            // Any in_fire this cycle is dropped; an out_fire has already
            // completed on the wire and needs no action here.
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
`ifdef PIPE_SKID_EN
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry behind main.
                        state_d = ST_FULL;
                        skid_d  = in_data;
`endif
                    end else if (out_fire) begin
                        // main keeps its old payload; out_valid drops.
                        state_d = ST_EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= FLUSH_VAL;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

`ifdef PIPE_SKID_EN
    // Status flags are precomputed from the next state so that in_ready and
    // occupancy are plain register outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
            case (state_d)
                ST_ONE:  occ_q <= 2'd1;
                ST_FULL: occ_q <= 2'd2;
                default: occ_q <= 2'd0;
            endcase
        end
    end
`endif

    // ------------------------------------------------------------------
    // Back-pressure counter: clear wins over increment; flush leaves it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Self-checking bench for pipe_stage_buf. A queue-based reference model tracks
// the entries held by the stage; every cycle the DUT outputs are compared with
// the model at the falling edge, then the model advances at the rising edge.
// Builds with or without PIPE_SKID_EN to match the DUT.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int unsigned       DATA_W    = 96;
    localparam logic [DATA_W-1:0] FLUSH_VAL = 96'h0F1E_2D3C_4B5A_6978_8796_A5B4;
    localparam int unsigned       CNT_W     = 4;
    localparam int unsigned       CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic              cnt_clr;

    pipe_stage_buf #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: entries held, the payload shown when empty, counter.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] shown;
    int unsigned       m_cnt;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_in_ready();
`ifdef PIPE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic iv, input logic [DATA_W-1:0] d,
                         input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    // One clock cycle: compare at negedge, advance the model at posedge,
    // return 1 time unit after the edge so callers can change inputs.
    task automatic step();
        logic                exp_valid;
        logic [DATA_W-1:0]   exp_data;
        logic                fire_in;
        logic                fire_out;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        exp_data  = shown;
        if (exp_valid) exp_data = q[0];
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("out_data", out_data, exp_data);
        check_eq("occupancy", occupancy, q.size());
        check_eq("in_ready", in_ready, m_in_ready());
        check_eq("stall_cnt", stall_cnt, m_cnt);
        fire_in  = in_valid && m_in_ready();
        fire_out = exp_valid && out_ready;
        @(posedge clk);
        if (reset) begin
            q.delete();
            shown = FLUSH_VAL;
            m_cnt = 0;
        end else begin
            if (cnt_clr) m_cnt = 0;
            else if (exp_valid && !out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                q.delete();
                shown = FLUSH_VAL;
            end else begin
                if (fire_out) shown = q.pop_front();
                if (fire_in) q.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic reset_cycle();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        shown = FLUSH_VAL;
        m_cnt = 0;

        // Reset values against constants.
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, FLUSH_VAL);
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        check_eq("rst_in_ready", in_ready, 1);

        // Stream 1..8 at full rate.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), 1'b1);
            step();
            check_eq("stream_data", out_data, i);
            check_eq("stream_valid", out_valid, 1);
        end
        drive(1'b0, '0, 1'b1);
        step();
        check_eq("stream_stall", stall_cnt, 0);
        step();

        // Back-pressure: A then B while out_ready is low.
        reset_cycle();
        drive(1'b1, DATA_W'('hA), 1'b0);
        step();
        drive(1'b1, DATA_W'('hB), 1'b0);
        step();
        check_eq("bp_out_data", out_data, 'hA);
`ifdef PIPE_SKID_EN
        check_eq("bp_occupancy", occupancy, 2);
        check_eq("bp_in_ready", in_ready, 0);
`else
        check_eq("bp_occupancy", occupancy, 1);
`endif
        drive(1'b0, '0, 1'b1);
        step();
`ifdef PIPE_SKID_EN
        check_eq("drain_b", out_data, 'hB);
        check_eq("drain_b_valid", out_valid, 1);
`else
        check_eq("drain_empty", out_valid, 0);
`endif
        step();
        check_eq("drain_done", out_valid, 0);

        // Flush while full with C on the input.
        drive(1'b1, DATA_W'('hA), 1'b0);
        step();
        drive(1'b1, DATA_W'('hB), 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, DATA_W'('hC), 1'b0);
        step();
        flush = 1'b0;
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_data", out_data, FLUSH_VAL);
        check_eq("flush_occ", occupancy, 0);
        drive(1'b0, '0, 1'b1);
        repeat (3) step();

        // Stall counter: count, saturate, clear.
        reset_cycle();
        drive(1'b1, DATA_W'('h55), 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        repeat (5) step();
        check_eq("stall_five", stall_cnt, 5);
        repeat ((1 << CNT_W) + 3 - 5) step();
        check_eq("stall_sat", stall_cnt, CNT_MAX);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check_eq("stall_clr", stall_cnt, 0);
        step();
        check_eq("stall_after_clr", stall_cnt, 1);

        // Reset in the middle of a stream.
        drive(1'b1, DATA_W'('h77), 1'b1);
        repeat (3) step();
        reset = 1'b1;
        drive(1'b1, DATA_W'('h99), 1'b1);
        step();
        reset = 1'b0;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", out_data, FLUSH_VAL);
        check_eq("mid_rst_occ", occupancy, 0);
        check_eq("mid_rst_cnt", stall_cnt, 0);
        check_eq("mid_rst_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rand_data(), 1'b1);
            step();
        end

        // Randomised traffic with occasional flush, clear and reset.
        for (int blk = 0; blk < 10; blk++) begin
            int unsigned bias;
            bias = $urandom_range(1, 4);
            for (int c = 0; c < 1000; c++) begin
                drive(($urandom_range(0, 3) != 0), rand_data(),
                      ($urandom_range(0, 4) >= bias));
                flush   = ($urandom_range(0, 63) == 0);
                cnt_clr = ($urandom_range(0, 49) == 0);
                reset   = ($urandom_range(0, 996) == 0);
                step();
            end
        end
        flush   = 1'b0;
        cnt_clr = 1'b0;
        reset   = 1'b0;
        drive(1'b0, '0, 1'b1);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It replaces the fixed-width, enable-based stage registers between the CPU pipeline stages (IF/ID, ID/EX, ...) and carries any payload width. It also loads a programmable bubble value on flush and counts back-pressure cycles for performance debug.

## Interface
- DATA_W, 96: payload width in bits, for example {pc[63:0], instr[31:0]}.
- FLUSH_VAL, {DATA_W{1'b0}}: value loaded into out_data on reset or flush.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  output payload.
- occupancy  out  2  number of entries held (0..2).
- stall_cnt  out  CNT_W  saturating count of back-pressure cycles.
- cnt_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main register (drives out_data/out_valid).
  - skid register (only when PIPE_SKID_EN is defined).
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2, skid build only).
- EMPTY:
  - in_fire -> ONE; main <= in_data.
- ONE:
  - in_fire & out_fire -> ONE; main <= in_data.
  - in_fire & !out_fire -> FULL; skid <= in_data. In the non-skid build this case cannot occur.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready = 0.
  - out_fire -> ONE; main <= skid.
  - Otherwise hold.
- out_data holds its last value when going to EMPTY. Only reset and flush load FLUSH_VAL.
- Priority is reset > flush > normal transfer.
- Flush:
  - Next state EMPTY; out_data <= FLUSH_VAL; skid is invalidated.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as a completed downstream transfer.
- stall_cnt:
  - Increments in every cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - cnt_clr takes priority over increment (clear wins). Reset also clears it.
  - Flush does not clear it.
- Entries leave in strict FIFO order, with no duplication and no loss except by flush.

## Timing
- Reset values: out_valid=0, out_data=FLUSH_VAL, occupancy=0, stall_cnt=0. in_ready is 1 from the first cycle after reset.
- Latency: in_fire in cycle N -> out_valid with that data in cycle N+1.
- Throughput: 1 entry per cycle when out_ready is held high.
- Every output is registered except in_ready in the non-skid build.
- Once out_valid is asserted, out_valid and out_data stay stable until out_fire or flush.

## Configuration
- PIPE_SKID_EN defined:
  - Two-entry skid buffer.
  - in_ready = !skid_valid, driven from a register. There is no combinational path from out_ready to in_ready.
  - occupancy can reach 2.
- PIPE_SKID_EN undefined:
  - Single entry.
  - in_ready = !out_valid | out_ready, a combinational path.
  - FULL state does not exist; occupancy ≤ 1.
- Handshake semantics and latency are identical in both builds.

## Test plan
- Reset, then stream 0x1..0x8 with in_valid=1 and out_ready=1 -> out_data is 0x1..0x8 starting one cycle after the first in_fire; no gaps; stall_cnt=0.
- Send 0xA, then hold out_ready=0 while sending 0xB -> skid build: occupancy=2, in_ready=0, out_data=0xA. Then raise out_ready -> 0xA, then 0xB, in order.
- Hold out_ready=0 for 5 cycles with an entry valid -> stall_cnt=5. Hold it low for 2^CNT_W+3 cycles -> stall_cnt saturates at all-ones. Pulse cnt_clr in a stall cycle -> stall_cnt=0 the next cycle.
- With FULL (0xA, 0xB) assert flush while in_valid=1 carries 0xC -> next cycle out_valid=0, out_data=FLUSH_VAL, occupancy=0; 0xC never appears at the output.
- Assert reset mid-stream with out_valid=1 -> next cycle every output equals its reset value; the stream restarts cleanly.
- Random in_valid/out_ready (both builds, 10k cycles) -> scoreboard shows in-order, lossless delivery; out_data is stable while out_valid & !out_ready.
